lsu_bridge: RTL and testbench

Load/store unit sitting between the controller's `lsu_func`/`mem_wr` outputs and a word-addressed 32-bit data memory. It accepts one load or store per request and drives a request/acknowledge memory handshake with byte enables. It returns sign- or zero-extended load data to the register-file write path, and reports completion and access errors back to the core.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 69 ++++++
 rtl/lsu_bridge.sv | 125 ++++++++++++
 tb/tb_lsu_bridge.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bridge: function codes, access sizes, byte-enable
// patterns and FSM states.
package lsu_pkg;

    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } lsu_func_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_ERR
    } state_e;

    localparam int STORE_BIT = 3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational access decoder: legality, byte enables, store lane shift and load
// extract/extend for one load/store function code and byte offset.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]  func,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        legal,
    output logic        misaligned
);

    logic [1:0]  lane;
    logic [31:0] shifted;
    logic        sign_fill;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        lane       = 2'd0;
        be         = 4'b0000;
        misaligned = 1'b0;
        legal      = 1'b0;

        case (func)
            LB, LH, LW, LBU, LHU, SB, SH, SW: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase

        // Offset bits below the access size are dropped, so a half at offset 3 uses lanes 2-3.
        case (func[1:0])
            SIZE_BYTE: begin
                lane = offset;
                be   = BE_BYTE << offset;
            end
            SIZE_HALF: begin
                lane       = {offset[1], 1'b0};
                be         = BE_HALF << {offset[1], 1'b0};
                misaligned = offset[0];
            end
            SIZE_WORD: begin
                be         = BE_WORD;
                misaligned = |offset;
            end
            default: ;
        endcase

        wdata_lane = wdata << {lane, 3'b000};
        shifted    = rdata_raw >> {lane, 3'b000};
        sign_fill  = 1'b0;
        rdata_ext  = shifted;

        case (func[1:0])
            SIZE_BYTE: begin
                sign_fill = shifted[7] & ~func[2];
                rdata_ext = {{24{sign_fill}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                sign_fill = shifted[15] & ~func[2];
                rdata_ext = {{16{sign_fill}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_bridge.sv
// Load/store bridge from the core to a word-addressed 32-bit memory with req/ack handshake.
// Optional macro LSU_ALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module lsu_bridge
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              req,
    input  logic [3:0]        lsu_func,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    state_e      state;
    logic [3:0]  func_q;
    logic [1:0]  off_q;

    logic [3:0]  al_func;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_legal;
    logic        al_misaligned;
    logic        accept;

    // In IDLE the aligner decodes the incoming request; afterwards it serves the latched access.
    assign al_func = (state == ST_IDLE) ? lsu_func  : func_q;
    assign al_off  = (state == ST_IDLE) ? addr[1:0] : off_q;

    lsu_align u_align (
        .func       (al_func),
        .offset     (al_off),
        .wdata      (wdata),
        .rdata_raw  (mem_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .legal      (al_legal),
        .misaligned (al_misaligned)
    );

`ifdef LSU_ALIGN_CHECK_EN
    assign accept = al_legal && !al_misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = al_misaligned;
    assign accept = al_legal;
`endif

    // NOTE: state and registered outputs use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            state     <= ST_IDLE;
            func_q    <= '0;
            off_q     <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if (accept) begin
                            state     <= ST_REQ;
                            func_q    <= lsu_func;
                            off_q     <= addr[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= lsu_func[STORE_BIT];
                            mem_addr  <= addr[ADDR_W-1:2];
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state   <= ST_RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        if (!func_q[STORE_BIT]) begin
                            rdata <= al_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bridge.sv
// Self-checking bench for lsu_bridge: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of the access rules.
module tb_lsu_bridge;

    logic        clk = 1'b0;
    logic        _reset;
    logic        req;
    logic [3:0]  lsu_func;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_bridge #(.ADDR_W(32)) dut (
        .clk       (clk),
        ._reset    (_reset),
        .req       (req),
        .lsu_func  (lsu_func),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: derived directly from the access rules.
    function automatic bit m_legal(input logic [3:0] f, input logic [31:0] a);
        bit ok;
        if (f[3]) ok = (f[2:0] <= 3'd2);
        else      ok = (f[2:0] != 3'd3) && (f[2:0] <= 3'd5);
`ifdef LSU_ALIGN_CHECK_EN
        if (f[1:0] == 2'd1 && a[0])         ok = 1'b0;
        if (f[1:0] == 2'd2 && a[1:0] != 0)  ok = 1'b0;
`else
        if (a[0] === 1'bx) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic int m_bytes(input logic [3:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic int m_off(input logic [3:0] f, input logic [31:0] a);
        int n = m_bytes(f);
        return (int'(a % 4) / n) * n;
    endfunction

    function automatic logic [31:0] m_be(input logic [3:0] f, input logic [31:0] a);
        return ((32'd1 << m_bytes(f)) - 1) << m_off(f, a);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] wd);
        return wd << (8 * m_off(f, a));
    endfunction

    function automatic logic [31:0] m_rdata(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] md);
        int          n = m_bytes(f);
        logic [31:0] v = md >> (8 * m_off(f, a));
        logic [31:0] mask;
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 1;
        v    = v & mask;
        if (!f[2] && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // Called at a negedge with the bridge idle; returns at the negedge of the cycle after done/err.
    task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] md, input int delay, input bit poke, input bit junk_ack);
        bit legal = m_legal(f, a);
        req      = 1'b1;
        lsu_func = f;
        addr     = a;
        wdata    = wd;
        @(negedge clk);
        req      = 1'b0;
        lsu_func = 4'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
        if (!legal) begin
            check("err_pulse", err, 1);
            check("err_mem_req", mem_req, 0);
            check("err_done", done, 0);
            check("err_busy", busy, 1);
            @(negedge clk);
            check("err_clear", err, 0);
            check("err_busy_clear", busy, 0);
            check("err_no_mem_req", mem_req, 0);
            return;
        end
        check("req_mem_req", mem_req, 1);
        check("req_mem_we", mem_we, f[3]);
        check("req_mem_addr", mem_addr, a[31:2]);
        check("req_mem_be", mem_be, m_be(f, a));
        if (f[3]) check("req_mem_wdata", mem_wdata, m_wdata(f, a, wd));
        check("req_busy", busy, 1);
        check("req_done", done, 0);
        for (int i = 0; i < delay; i++) begin
            if (poke && i == 0) begin
                req      = 1'b1;
                lsu_func = 4'b0010;
                addr     = 32'h0000_0F00;
            end
            @(negedge clk);
            req = 1'b0;
            check("wait_mem_req", mem_req, 1);
            check("wait_mem_addr", mem_addr, a[31:2]);
            check("wait_mem_be", mem_be, m_be(f, a));
            check("wait_done", done, 0);
        end
        mem_ack   = 1'b1;
        mem_rdata = md;
        @(negedge clk);
        mem_ack   = junk_ack;
        mem_rdata = $urandom;
        check("resp_done", done, 1);
        check("resp_err", err, 0);
        check("resp_mem_req", mem_req, 0);
        check("resp_busy", busy, 1);
        if (!f[3]) check("resp_rdata", rdata, m_rdata(f, a, md));
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_mem_req", mem_req, 0);
    endtask

    initial begin
        _reset    = 1'b0;
        req       = 1'b0;
        lsu_func  = 4'd0;
        addr      = '0;
        wdata     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_state", {mem_req, mem_we, done, err, busy}, 5'b0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        _reset = 1'b1;
        @(negedge clk);

        // Directed scenarios.
        run_op(4'b1010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
        run_op(4'b0010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        run_op(4'b0000, 32'h003, 32'h0, 32'h80FF_7F01, 0, 0, 0);
        run_op(4'b0100, 32'h003, 32'h0, 32'h80FF_7F01, 0, 0, 0);
        run_op(4'b0000, 32'h001, 32'h0, 32'h80FF_7F01, 0, 0, 0);
        run_op(4'b1001, 32'h102, 32'h0000_1234, 32'h0, 0, 0, 0);
        run_op(4'b0001, 32'h102, 32'h0, 32'h8001_5A5A, 1, 0, 0);
        run_op(4'b0010, 32'h104, 32'h0, 32'h1357_9BDF, 5, 1, 1);
        run_op(4'b0011, 32'h108, 32'h0, 32'h0, 0, 0, 0);
        run_op(4'b0010, 32'h101, 32'h0, 32'h1122_3344, 0, 0, 0);
        run_op(4'b0101, 32'h003, 32'h0, 32'hFEDC_BA98, 2, 0, 0);

        // Reset while a request is outstanding.
        req      = 1'b1;
        lsu_func = 4'b0010;
        addr     = 32'h200;
        @(negedge clk);
        req = 1'b0;
        check("mid_rst_mem_req_before", mem_req, 1);
        _reset = 1'b0;
        @(negedge clk);
        check("mid_rst_mem_req", mem_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        _reset = 1'b1;
        @(negedge clk);
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);
        run_op(4'b0010, 32'h204, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

        // Randomized accesses.
        for (int n = 0; n < 300; n++) begin
            run_op(4'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
